cp0_reg: RTL and testbench

- MIPS CP0 register file in the memory stage.
- Consumes the exception unit's except_type, pc and bad-address results. Produces the registered Status/Cause/EPC values that feed back into the exception unit's interrupt and return-address logic.
- Also handles mtc0/mfc0 access, Count/Compare timer interrupt generation and external interrupt sampling.

---
 rtl/cp0_reg.sv | 179 +++++++++++++++++
 tb/tb_cp0_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS CP0 register file in the memory stage.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. It takes the exception
// unit's result (except_type_i, pc_i, is_in_delayslot_i, badvaddr_i) and feeds
// the registered Status/Cause/EPC values back to it.
// It also handles mtc0/mfc0 access, the Count/Compare timer interrupt, and
// sampling of the external interrupt lines into Cause.IP[7:2].
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  mtc0 write port
//   raddr_i/rdata_o     mfc0 read port (combinational)
//   ext_int_i           hardware interrupt lines
//   except_type_i, pc_i, is_in_delayslot_i, badvaddr_i  exception inputs
//   status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  register values
//   timer_int_o         timer interrupt, equal to cause_o[30]
//
// Optional feature: define CP0_WRITE_BYPASS_EN to forward a same-cycle mtc0
// value to rdata_o. When the macro is undefined, mfc0 reads the current
// register contents.
module cp0_reg #(
    parameter logic [31:0] PRID         = 32'h0000_4220,
    parameter logic [31:0] STATUS_RST   = 32'h0040_0000,
    parameter logic [31:0] STATUS_WMASK = 32'h0000_ff03,
    parameter logic [31:0] CAUSE_WMASK  = 32'h0000_0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  ext_int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;
    localparam logic [4:0] RegPrid     = 5'd15;
    localparam logic [4:0] RegConfig   = 5'd16;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        tick_q;

    logic exc, eret;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] status_wval, cause_wval;

    assign exc  = (except_type_i != 32'h0);
    assign eret = (except_type_i == 32'h0000_000e);

    // Count/Compare writes survive an exception. Status/Cause/EPC writes do not.
    assign wr_count   = we_i && (waddr_i == RegCount);
    assign wr_compare = we_i && (waddr_i == RegCompare);
    assign wr_status  = we_i && (waddr_i == RegStatus) && !exc;
    assign wr_cause   = we_i && (waddr_i == RegCause) && !exc;
    assign wr_epc     = we_i && (waddr_i == RegEpc) && !exc;

    assign status_wval = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    assign cause_wval  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);

    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (wr_count)       count_d = wdata_i;
        else if (tick_q)    count_d = count_q + 32'd1;

        if (wr_compare)     compare_d = wdata_i;
        if (wr_status)      status_d  = status_wval;
        if (wr_cause)       cause_d   = cause_wval;
        if (wr_epc)         epc_d     = wdata_i;

        cause_d[15:10] = ext_int_i;

        // Compare against the next Count so TI rises on the edge Count reaches Compare.
        if (count_d == compare_q && compare_q != 32'h0) cause_d[30] = 1'b1;
        if (wr_compare) cause_d[30] = 1'b0;

        if (exc) begin
            if (eret) begin
                status_d[1] = 1'b0;
            end else begin
                if (!status_q[1]) begin
                    epc_d       = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_d[31] = is_in_delayslot_i;
                end
                status_d[1] = 1'b1;
                case (except_type_i)
                    32'h01:  cause_d[6:2] = 5'h00;
                    32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0d:
                        cause_d[6:2] = except_type_i[4:0];
                    default: ;
                endcase
                if (except_type_i == 32'h04 || except_type_i == 32'h05) badvaddr_d = badvaddr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= 1'b0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            status_q   <= STATUS_RST;
            cause_q    <= 32'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
        end else begin
            tick_q     <= ~tick_q;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        unique case (raddr_i)
            RegBadVAddr: rdata_o = badvaddr_q;
            RegCount:    rdata_o = count_q;
            RegCompare:  rdata_o = compare_q;
            RegStatus:   rdata_o = status_q;
            RegCause:    rdata_o = cause_q;
            RegEpc:      rdata_o = epc_q;
            RegPrid:     rdata_o = PRID;
            RegConfig:   rdata_o = 32'h8000_0000;
            default:     rdata_o = 32'h0;
        endcase
`ifdef CP0_WRITE_BYPASS_EN
        if (we_i && !exc && (waddr_i == raddr_i)) begin
            case (waddr_i)
                RegCount:   rdata_o = wdata_i;
                RegCompare: rdata_o = wdata_i;
                RegStatus:  rdata_o = status_wval;
                RegCause:   rdata_o = cause_wval;
                RegEpc:     rdata_o = wdata_i;
                default:    ;
            endcase
        end
`endif
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = cause_q[30];

endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  ext_int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_reg dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .ext_int_i         (ext_int_i),
        .except_type_i     (except_type_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .badvaddr_i        (badvaddr_i),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .badvaddr_o        (badvaddr_o),
        .timer_int_o       (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock edge; returns at the following negedge, where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0; raddr_i = 5'd0;
        ext_int_i = 6'd0; except_type_i = 32'h0; pc_i = 32'h0;
        is_in_delayslot_i = 1'b0; badvaddr_i = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic raise(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bad);
        except_type_i = code; pc_i = pc; is_in_delayslot_i = ds; badvaddr_i = bad;
        step();
        except_type_i = 32'h0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Reset values and Count rate
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_count", count_o, 32'h0);
        check("rst_timer", {31'h0, timer_int_o}, 32'h0);
        for (int i = 0; i < 10; i++) step();
        check("count_10cyc", count_o, 32'd5);

        // Timer interrupt
        do_reset();
        mtc0(5'd11, 32'd8);
        check("compare_w", compare_o, 32'd8);
        for (int i = 0; i < 40; i++) begin
            if (count_o == 32'd8) break;
            if (count_o == 32'd7) check("ti_before", {31'h0, timer_int_o}, 32'h0);
            step();
        end
        check("count_reach8", count_o, 32'd8);
        check("ti_rise", {31'h0, timer_int_o}, 32'h1);
        check("cause_ti", {31'h0, cause_o[30]}, 32'h1);
        step();
        check("ti_sticky", {31'h0, timer_int_o}, 32'h1);
        mtc0(5'd11, 32'd20);
        check("ti_clear", {31'h0, timer_int_o}, 32'h0);
        check("compare_20", compare_o, 32'd20);

        // Exception in delay slot, then eret
        do_reset();
        raise(32'h0a, 32'hbfc0_0100, 1'b1, 32'h0);
        check("exc_epc", epc_o, 32'hbfc0_00fc);
        check("exc_bd", {31'h0, cause_o[31]}, 32'h1);
        check("exc_code", {27'h0, cause_o[6:2]}, 32'h0a);
        check("exc_exl", {31'h0, status_o[1]}, 32'h1);
        raise(32'h0e, 32'h0, 1'b0, 32'h0);
        check("eret_exl", {31'h0, status_o[1]}, 32'h0);
        check("eret_epc", epc_o, 32'hbfc0_00fc);

        // Address error with BadVAddr, then nested exception under EXL
        raise(32'h04, 32'h0000_0100, 1'b0, 32'h0000_1003);
        check("adel_bad", badvaddr_o, 32'h0000_1003);
        check("adel_code", {27'h0, cause_o[6:2]}, 32'h04);
        check("adel_epc", epc_o, 32'h0000_0100);
        check("adel_bd", {31'h0, cause_o[31]}, 32'h0);
        raise(32'h08, 32'h0000_0200, 1'b1, 32'h0000_5555);
        check("nest_epc", epc_o, 32'h0000_0100);
        check("nest_bd", {31'h0, cause_o[31]}, 32'h0);
        check("nest_code", {27'h0, cause_o[6:2]}, 32'h08);
        check("nest_bad", badvaddr_o, 32'h0000_1003);
        raise(32'h03, 32'h0000_0300, 1'b0, 32'h0);
        check("unlisted_code", {27'h0, cause_o[6:2]}, 32'h08);

        // Read decode
        raddr_i = 5'd8;  #1 check("rd_bad", rdata_o, 32'h0000_1003);
        raddr_i = 5'd14; #1 check("rd_epc", rdata_o, 32'h0000_0100);
        raddr_i = 5'd15; #1 check("rd_prid", rdata_o, 32'h0000_4220);
        raddr_i = 5'd16; #1 check("rd_config", rdata_o, 32'h8000_0000);
        raddr_i = 5'd3;  #1 check("rd_other", rdata_o, 32'h0);
        raddr_i = 5'd0;

        // Status write mask, and exception overriding a Status write
        do_reset();
        mtc0(5'd12, 32'hffff_ffff);
        check("status_mask", status_o, 32'h0040_ff03);
        mtc0(5'd15, 32'h1234_5678);
        raddr_i = 5'd15; #1 check("prid_ro", rdata_o, 32'h0000_4220);
        raddr_i = 5'd0;
        do_reset();
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hffff_ffff;
        raise(32'h0c, 32'h0000_0400, 1'b0, 32'h0);
        we_i = 1'b0;
        check("status_exc", status_o, 32'h0040_0002);
        check("status_exc_code", {27'h0, cause_o[6:2]}, 32'h0c);

        // Cause mask, external interrupt sampling, Count wrap
        do_reset();
        mtc0(5'd13, 32'hffff_ffff);
        check("cause_mask", cause_o, 32'h0000_0300);
        ext_int_i = 6'b100001;
        step();
        check("ext_int", cause_o, 32'h0000_8700);
        ext_int_i = 6'd0;
        do_reset();
        mtc0(5'd9, 32'hffff_ffff);
        check("count_load", count_o, 32'hffff_ffff);
        step();
        check("count_wrap", count_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
